// File: rtl/seven_seg_pkg.sv
// Shared constants for the multiplexed seven-segment scanner.
// Glyphs are logical active-high, packed abcdefg (bit 6 = a).
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [15:0][6:0] GLYPH = {
    7'h47, 7'h4F, 7'h3D, 7'h4E,
    7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33,
    7'h79, 7'h6D, 7'h30, 7'h7E
  };

endpackage

// File: rtl/seven_seg_decode.sv
// Hex nibble to logical abcdefg glyph.
// Purely combinational table lookup.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] glyph
);

  assign glyph = GLYPH[nib];

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed seven-segment scanner with double-buffered
// frame-atomic updates and per-slot anti-ghost blanking.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  localparam logic [6:0] SEG_OFF = SEG_BLANK ^ {7{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{ACTIVE_LOW}};

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;

  logic [4*NUM_DIGITS-1:0] pdata_q, pdata_d;
  logic [NUM_DIGITS-1:0]   pdp_q, pdp_d;
  logic [NUM_DIGITS-1:0]   pen_q, pen_d;
  logic                    pvld_q, pvld_d;

  logic [4*NUM_DIGITS-1:0] adata_q, adata_d;
  logic [NUM_DIGITS-1:0]   adp_q, adp_d;
  logic [NUM_DIGITS-1:0]   aen_q, aen_d;

  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  fd_q, fd_d;

  logic                  slot_end;
  logic                  frame_end;
  logic                  blank;
  logic [3:0]            nib;
  logic [6:0]            glyph;
  logic [NUM_DIGITS-1:0] lit_an;

  assign nib = adata_q[{idx_q, 2'b00} +: 4];

  seven_seg_decode u_dec (
    .nib   (nib),
    .glyph (glyph)
  );

  always_comb begin
    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);

    cnt_d = slot_end ? '0 : cnt_q + CW'(1);
    idx_d = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end

    pdata_d = pdata_q;
    pdp_d   = pdp_q;
    pen_d   = pen_q;
    pvld_d  = pvld_q;
    adata_d = adata_q;
    adp_d   = adp_q;
    aen_d   = aen_q;

    // Transfer takes the old pending copy; a same-cycle load
    // lands in pending and waits for the next boundary.
    if (frame_end && pvld_q) begin
      adata_d = pdata_q;
      adp_d   = pdp_q;
      aen_d   = pen_q;
      pvld_d  = 1'b0;
    end
    if (load) begin
      pdata_d = data;
      pdp_d   = dp_in;
      pen_d   = digit_en;
      pvld_d  = 1'b1;
    end

    blank  = (cnt_q < CNT_BLANK) || !aen_q[idx_q];
    lit_an = '0;
    lit_an[idx_q] = 1'b1;

    an_d  = (blank ? '0 : lit_an) ^ AN_OFF;
    seg_d = (blank ? SEG_BLANK : glyph) ^ {7{ACTIVE_LOW}};
    dp_d  = (!blank && adp_q[idx_q]) ^ ACTIVE_LOW;
    fd_d  = frame_end;
  end

  // Enables come up set so a freshly reset display shows 0s.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      pdata_q <= '0;
      pdp_q   <= '0;
      pen_q   <= '1;
      pvld_q  <= 1'b0;
      adata_q <= '0;
      adp_q   <= '0;
      aen_q   <= '1;
      seg_q   <= SEG_OFF;
      dp_q    <= ACTIVE_LOW;
      an_q    <= AN_OFF;
      fd_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pdata_q <= pdata_d;
      pdp_q   <= pdp_d;
      pen_q   <= pen_d;
      pvld_q  <= pvld_d;
      adata_q <= adata_d;
      adp_q   <= adp_d;
      aen_q   <= aen_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      fd_q    <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan: a cycle model pushes the
// expected output word each edge, scenario tasks pop and compare.
module tb_seven_seg_scan;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BL = 2;
  localparam int FR = ND * RD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = 4'hF;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  seven_seg_scan #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BL),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .load       (load),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [12:0] got;
  assign got = {an, seg, dp, frame_done};

  function automatic logic [6:0] hexseg(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;
      4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;
      4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;
      default: return 7'b1000111;
    endcase
  endfunction

  function automatic logic [12:0] model_out(
    input int t, input logic [15:0] ad,
    input logic [3:0] adp, input logic [3:0] aen);
    int  s;
    int  d;
    logic fe;
    s  = t % RD;
    d  = (t / RD) % ND;
    fe = (s == RD - 1) && (d == ND - 1);
    if (s < BL || !aen[d]) return {4'hF, 7'h7F, 1'b1, fe};
    return {~(4'b0001 << d), ~hexseg(ad[d*4 +: 4]), ~adp[d], fe};
  endfunction

  logic [12:0] sb[$];
  int          m_t;
  logic [15:0] m_pd, m_ad;
  logic [3:0]  m_pdp, m_adp, m_pen, m_aen;
  logic        m_pv;

  always @(posedge clk) begin
    if (rst) begin
      sb.push_back({4'hF, 7'h7F, 1'b1, 1'b0});
      m_t   <= 0;
      m_pd  <= '0;
      m_ad  <= '0;
      m_pdp <= '0;
      m_adp <= '0;
      m_pen <= '1;
      m_aen <= '1;
      m_pv  <= 1'b0;
    end else begin
      sb.push_back(model_out(m_t, m_ad, m_adp, m_aen));
      if (m_t % FR == FR - 1 && m_pv) begin
        m_ad  <= m_pd;
        m_adp <= m_pdp;
        m_aen <= m_pen;
        m_pv  <= 1'b0;
      end
      if (load) begin
        m_pd  <= data;
        m_pdp <= dp_in;
        m_pen <= digit_en;
        m_pv  <= 1'b1;
      end
      m_t <= m_t + 1;
    end
  end

  logic [12:0] exp_v;

  task automatic tick();
    @(negedge clk);
    if (sb.size() == 0) exp_v = 'x;
    else exp_v = sb.pop_front();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL reset_sb got=%h exp=%h", got, exp_v);
      end
      n_vec++;
      if (got !== 13'h1FFE) begin
        n_err++;
        $display("FAIL reset_off got=%h exp=%h", got, 13'h1FFE);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int d0, d1, d2, d3, off, npulse, last;
    d0 = 0; d1 = 0; d2 = 0; d3 = 0; off = 0;
    npulse = 0; last = -1;
    for (int i = 0; i < 3 * FR; i++) begin
      load = (i == 0);
      if (i == 0) begin
        data = 16'h1234; dp_in = 4'b0010; digit_en = 4'hF;
      end
      tick();
      n_vec++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL basic_sb i=%0d got=%h exp=%h", i, got, exp_v);
      end
      if (frame_done) begin
        npulse++;
        if (last >= 0 && i - last != FR) begin
          n_err++;
          $display("FAIL fd_period got=%0d exp=%0d", i - last, FR);
        end
        if (last >= 0) n_vec++;
        last = i;
      end
      if (i >= 2 * FR) begin
        if (an == 4'b1110 && seg == 7'h4C && dp) d0++;
        if (an == 4'b1101 && seg == 7'h06 && !dp) d1++;
        if (an == 4'b1011 && seg == 7'h12 && dp) d2++;
        if (an == 4'b0111 && seg == 7'h4F && dp) d3++;
        if (an == 4'hF && seg == 7'h7F && dp) off++;
      end
    end
    load = 1'b0;
    n_vec += 6;
    if (npulse != 3) begin
      n_err++; $display("FAIL fd_count got=%0d exp=3", npulse);
    end
    if (d0 != 6) begin n_err++; $display("FAIL dig0_4 got=%0d exp=6", d0); end
    if (d1 != 6) begin n_err++; $display("FAIL dig1_3dp got=%0d exp=6", d1); end
    if (d2 != 6) begin n_err++; $display("FAIL dig2_2 got=%0d exp=6", d2); end
    if (d3 != 6) begin n_err++; $display("FAIL dig3_1 got=%0d exp=6", d3); end
    if (off != 8) begin n_err++; $display("FAIL blank_slots got=%0d exp=8", off); end
  endtask

  task automatic test_last_wins();
    int wa, wb, nb, na;
    wa = (5 - m_t % FR + FR) % FR;
    wb = (20 - m_t % FR + FR) % FR;
    nb = 0; na = 0;
    for (int i = 0; i < 3 * FR; i++) begin
      load = (i == wa) || (i == wb);
      if (i == wa) data = 16'hAAAA;
      if (i == wb) data = 16'hBBBB;
      dp_in = 4'b0000; digit_en = 4'hF;
      tick();
      n_vec++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL lastwin_sb i=%0d got=%h exp=%h", i, got, exp_v);
      end
      if (an != 4'hF && seg == 7'h08) na++;
      if (i >= FR && an != 4'hF && seg == 7'h60) nb++;
    end
    load = 1'b0;
    n_vec += 2;
    if (na != 0) begin n_err++; $display("FAIL no_A got=%0d exp=0", na); end
    if (nb != 48) begin n_err++; $display("FAIL only_B got=%0d exp=48", nb); end
  endtask

  task automatic test_wrap_load();
    int w, nold, nnew;
    w = (FR - 1 - m_t % FR + FR) % FR;
    nold = 0; nnew = 0;
    for (int i = 0; i < w + 1 + 2 * FR; i++) begin
      load = (i == w);
      if (i == w) data = 16'hCCCC;
      tick();
      n_vec++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL wrap_sb i=%0d got=%h exp=%h", i, got, exp_v);
      end
      if (i > w && i <= w + FR && an != 4'hF && seg == 7'h60) nold++;
      if (i > w + FR && an != 4'hF && seg == 7'h31) nnew++;
    end
    load = 1'b0;
    n_vec += 2;
    if (nold != 24) begin n_err++; $display("FAIL wrap_old got=%0d exp=24", nold); end
    if (nnew != 24) begin n_err++; $display("FAIL wrap_new got=%0d exp=24", nnew); end
  endtask

  task automatic test_digit_en();
    int bad, off, n8, n6;
    bad = 0; off = 0; n8 = 0; n6 = 0;
    for (int i = 0; i < 3 * FR; i++) begin
      load = (i == 0);
      if (i == 0) begin
        data = 16'h5678; dp_in = 4'b0000; digit_en = 4'b0101;
      end
      tick();
      n_vec++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL den_sb i=%0d got=%h exp=%h", i, got, exp_v);
      end
      if (i >= FR && (!an[1] || !an[3])) bad++;
      if (i >= 2 * FR) begin
        if (an == 4'hF && seg == 7'h7F && dp) off++;
        if (an == 4'b1110 && seg == 7'h00) n8++;
        if (an == 4'b1011 && seg == 7'h20) n6++;
      end
    end
    load = 1'b0; digit_en = 4'hF;
    n_vec += 4;
    if (bad != 0) begin n_err++; $display("FAIL den_sel got=%0d exp=0", bad); end
    if (off != 20) begin n_err++; $display("FAIL den_off got=%0d exp=20", off); end
    if (n8 != 6) begin n_err++; $display("FAIL den_d0 got=%0d exp=6", n8); end
    if (n6 != 6) begin n_err++; $display("FAIL den_d2 got=%0d exp=6", n6); end
  endtask

  task automatic test_reset_mid();
    int wl, wr, n9, n0, nd0;
    wl = (10 - m_t % FR + FR) % FR;
    wr = wl + 10;
    n9 = 0; n0 = 0; nd0 = 0;
    for (int i = 0; i < wr + 1 + 2 * FR; i++) begin
      load = (i == wl);
      if (i == wl) begin
        data = 16'h9999; dp_in = 4'b0000; digit_en = 4'hF;
      end
      rst = (i == wr);
      tick();
      n_vec++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL rstmid_sb i=%0d got=%h exp=%h", i, got, exp_v);
      end
      if (i == wr) begin
        n_vec++;
        if (got !== 13'h1FFE) begin
          n_err++; $display("FAIL rstmid_off got=%h exp=%h", got, 13'h1FFE);
        end
      end
      if (i == wr + 3) begin
        n_vec++;
        if (an !== 4'b1110 || seg !== 7'h01) begin
          n_err++;
          $display("FAIL rstmid_dig0 got=%h/%h exp=e/01", an, seg);
        end
      end
      if (i > wr && seg == 7'h04) n9++;
      if (i > wr + FR) begin
        if (an != 4'hF && seg == 7'h01) n0++;
        if (an == 4'b1110 && seg == 7'h01 && dp) nd0++;
      end
    end
    rst = 1'b0; load = 1'b0;
    n_vec += 3;
    if (n9 != 0) begin n_err++; $display("FAIL rstmid_drop got=%0d exp=0", n9); end
    if (n0 != 24) begin n_err++; $display("FAIL rstmid_zero got=%0d exp=24", n0); end
    if (nd0 != 6) begin n_err++; $display("FAIL rstmid_d0 got=%0d exp=6", nd0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_last_wins();
    test_wrap_load();
    test_digit_en();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of multiplexed digits; legal range 1..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 100000, clock cycles per digit slot; legal range ≥ 4.
REQ-003 SHALL have parameter BLANK_CYCLES, default 1000, all-off cycles at the start of each slot (anti-ghosting); legal range 0..REFRESH_DIV-1.
REQ-004 SHALL have parameter ACTIVE_LOW, default 1; 1 means segment, dp and anode lines are driven low to light (common-anode).
REQ-005 clk  in  1  sole clock; all logic on the rising edge.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 data  in  4*NUM_DIGITS  hex nibbles; nibble k drives digit k, digit 0 rightmost.
REQ-008 dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit.
REQ-009 digit_en  in  NUM_DIGITS  per-digit enable, 0 = digit blanked.
REQ-010 load  in  1  single-cycle strobe capturing data, dp_in and digit_en into the pending buffer.
REQ-011 seg  out  7  segments; seg[6]=a … seg[0]=g.
REQ-012 dp  out  1  decimal point of the active digit.
REQ-013 an  out  NUM_DIGITS  anode selects, one-hot (active level per ACTIVE_LOW) or all off.
REQ-014 frame_done  out  1  one-cycle pulse at each frame boundary.

Function
REQ-015 Slot counter SHALL count 0..REFRESH_DIV-1 and wrap; at terminal count the digit index SHALL advance by 1, wrapping NUM_DIGITS-1 -> 0.
REQ-016 load SHALL write the pending buffer and set pending_valid; a later load before transfer SHALL overwrite it (last-wins).
REQ-017 At the frame boundary (index wraps to 0), if pending_valid the pending buffer SHALL be copied to the active buffer and pending_valid cleared; display SHALL never mix two loads within one frame.
REQ-018 A load in the same cycle as a frame boundary SHALL NOT be used for that transfer; it SHALL be transferred at the next boundary.
REQ-019 Decode SHALL produce the standard hex glyphs 0-9, A, b, C, d, E, F. In logical active-high abcdefg form: 0=1111110, 1=0110000, 8=1111111, F=1000111.
REQ-020 When ACTIVE_LOW=1, seg, dp and an SHALL be the bitwise inverse of the logical values.
REQ-021 While slot counter < BLANK_CYCLES, or the active digit_en bit is 0, all anodes, segments and dp SHALL be off.
REQ-022 Otherwise only an[index] SHALL be on, seg = glyph(active nibble[index]), dp = active dp_in[index].
REQ-023 seg, dp and an SHALL be registered, one cycle of latency after the counter/index state they reflect; no combinational path from inputs to outputs.
REQ-024 frame_done SHALL pulse high for exactly one cycle, registered, in the cycle after the index wraps to 0.
REQ-025 When NUM_DIGITS=1, index SHALL stay 0 and frame_done SHALL pulse every REFRESH_DIV cycles.

Reset
REQ-026 While rst is high at a clock edge: slot counter=0, index=0, pending and active buffers=0, pending_valid=0, frame_done=0, and all seg/dp/an off (all ones when ACTIVE_LOW=1).
REQ-027 A reset asserted mid-slot or mid-frame SHALL discard any pending load; scanning SHALL restart at digit 0 slot count 0 the cycle after rst falls.

Structure
REQ-028 Package seven_seg_pkg SHALL hold the 16-entry logical glyph constants and the blank-pattern constant.
REQ-029 Sub-module seven_seg_decode (combinational, 4-bit nibble -> 7-bit logical glyph) SHALL be instantiated once; the top SHALL hold the counters, buffers and polarity/blanking registers.

Verification (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, ACTIVE_LOW=1)
REQ-030 Reset then load data=16'h1234, dp_in=4'b0010, digit_en=4'hF -> from the first frame after transfer, digit 0 shows 4, digit 1 shows 3 with dp=0, the others dp=1; each an one-hot low for 6 of 8 cycles per slot.
REQ-031 Slot-timing check -> in each slot: an=4'hF and seg=7'h7F for 2 cycles, then digit active for 6; frame_done pulses once every 32 cycles.
REQ-032 load 16'hAAAA mid-frame, then 16'hBBBB mid-same-frame -> the next frame displays only B glyphs; no A is ever shown.
REQ-033 load coincident with index wrap -> the old value persists for the current frame; the new value appears one frame later.
REQ-034 digit_en=4'b0101 -> an never selects digits 1 or 3; their slots stay all-off.
REQ-035 rst pulsed mid-slot on digit 2 -> outputs off the next cycle, the pending load is discarded, scanning resumes at digit 0 with buffers zero (shows 0 glyph, 7'b0000001).
